// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mod_exp_ctrl
//  Brief    : Left-to-right square-and-multiply sequencer driving an external
//             ModMul unit; computes base^exponent mod p.
//  Revision : 1.0
// ============================================================================
module mod_exp_ctrl #(
    parameter int P_WIDTH = 256,
    parameter int E_WIDTH = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [P_WIDTH-1:0] base,
    input  logic [E_WIDTH-1:0] exponent,
    output logic               busy,
    output logic [P_WIDTH-1:0] result,
    output logic               done,
    output logic               mm_reset,
    output logic               mm_enable,
    output logic [P_WIDTH-1:0] mm_a,
    output logic [P_WIDTH-1:0] mm_b,
    input  logic [P_WIDTH-1:0] mm_r,
    input  logic               mm_done
);

    localparam int                  c_IDX_W   = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0]  c_IDX_TOP = c_IDX_W'(E_WIDTH - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE = c_IDX_W'(1);
    localparam logic [P_WIDTH-1:0]  c_ONE     = P_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SQ_ISSUE  = 3'd1,
        S_SQ_WAIT   = 3'd2,
        S_MUL_ISSUE = 3'd3,
        S_MUL_WAIT  = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t               r_state;
    logic [P_WIDTH-1:0]   r_acc;
    logic [P_WIDTH-1:0]   r_base;
    logic [E_WIDTH-1:0]   r_exp;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_first;

    logic                 w_bit;
    logic                 w_last;
    logic                 w_mm_valid;

    assign w_bit      = r_exp[r_idx];
    assign w_last     = (r_idx == '0);
    // The first WAIT cycle can still see mm_done from the previous product.
    assign w_mm_valid = mm_done && !r_first;

    // Outputs are registered: each transition loads the values the next
    // state must present, so ISSUE states carry mm_reset and operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_base    <= '0;
            r_exp     <= '0;
            r_idx     <= '0;
            r_first   <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            mm_reset  <= 1'b0;
            mm_enable <= 1'b0;
            mm_a      <= '0;
            mm_b      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base   <= base;
                        r_exp    <= exponent;
                        r_acc    <= c_ONE;
                        r_idx    <= c_IDX_TOP;
                        busy     <= 1'b1;
                        mm_reset <= 1'b1;
                        mm_a     <= c_ONE;
                        mm_b     <= c_ONE;
                        r_state  <= S_SQ_ISSUE;
                    end
                end

                S_SQ_ISSUE, S_MUL_ISSUE: begin
                    mm_reset  <= 1'b0;
                    mm_enable <= 1'b1;
                    r_first   <= 1'b1;
                    r_state   <= (r_state == S_SQ_ISSUE) ? S_SQ_WAIT : S_MUL_WAIT;
                end

                S_SQ_WAIT, S_MUL_WAIT: begin
                    r_first <= 1'b0;
                    if (w_mm_valid) begin
                        r_acc     <= mm_r;
                        mm_enable <= 1'b0;
                        if (r_state == S_SQ_WAIT && w_bit) begin
                            mm_reset <= 1'b1;
                            mm_a     <= mm_r;
                            mm_b     <= r_base;
                            r_state  <= S_MUL_ISSUE;
                        end else if (w_last) begin
                            // result takes the same value acc receives here,
                            // so it is valid alongside the done pulse.
                            result  <= mm_r;
                            done    <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx    <= r_idx - c_IDX_ONE;
                            mm_reset <= 1'b1;
                            mm_a     <= mm_r;
                            mm_b     <= mm_r;
                            r_state  <= S_SQ_ISSUE;
                        end
                    end
                end

                S_FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    mm_reset  <= 1'b0;
                    mm_enable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter P_WIDTH, default 256, giving the operand, result and ModMul data width.
REQ-002 SHALL have parameter E_WIDTH, default 256, giving the exponent width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new exponentiation; sampled only in IDLE.
REQ-006 SHALL have port base, input, P_WIDTH bits: base operand, already reduced below the modulus.
REQ-007 SHALL have port exponent, input, E_WIDTH bits: exponent.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port result, output, P_WIDTH bits: base^exponent mod p.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port mm_reset, output, 1 bit: active-high clear to the ModMul unit.
REQ-012 SHALL have port mm_enable, output, 1 bit: ModMul request.
REQ-013 SHALL have port mm_a, output, P_WIDTH bits: first ModMul operand.
REQ-014 SHALL have port mm_b, output, P_WIDTH bits: second ModMul operand.
REQ-015 SHALL have port mm_r, input, P_WIDTH bits: ModMul remainder.
REQ-016 SHALL have port mm_done, input, 1 bit: ModMul result valid (level; may stay high until the next mm_reset).

Function
REQ-017 SHALL implement left-to-right square-and-multiply.
- Algorithm: acc = 1; for i = E_WIDTH-1 down to 0: acc = acc*acc; if exponent[i] then acc = acc*base.
- Cost: exactly E_WIDTH squarings plus popcount(exponent) multiplies.
- Leading-zero bits are not skipped.
REQ-018 SHALL use states IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
REQ-019 IDLE, start=1: SHALL latch base and exponent, set acc = 1 and bit index = E_WIDTH-1, and go to SQ_ISSUE.
REQ-020 IDLE, start=0: SHALL remain in IDLE.
REQ-021 SQ_ISSUE / MUL_ISSUE SHALL, for exactly one cycle:
- drive mm_reset=1 and mm_enable=0;
- drive mm_a=acc, with mm_b=acc (square) or mm_b=latched base (multiply);
- move to the matching WAIT state.
REQ-022 SQ_WAIT / MUL_WAIT SHALL hold mm_enable=1 with mm_a/mm_b stable until the first cycle mm_done=1 is sampled.
REQ-023 mm_done in the WAIT state's first cycle SHALL be ignored, since it is stale from the prior transaction.
REQ-024 On a valid mm_done SHALL load acc with mm_r and drop mm_enable in the next cycle; there is no timeout, and any ModMul latency ≥1 SHALL be tolerated.
REQ-025 Completing SQ_WAIT: SHALL go to MUL_ISSUE if exponent[index]=1.
REQ-026 Completing SQ_WAIT with exponent[index]=0: SHALL go to FINISH if index=0, otherwise decrement index and go to SQ_ISSUE.
REQ-027 Completing MUL_WAIT: SHALL go to FINISH if index=0, otherwise decrement index and go to SQ_ISSUE.
REQ-028 FINISH SHALL copy acc to result, pulse done for one cycle, and return to IDLE.
REQ-029 result SHALL hold its value until the next FINISH.
REQ-030 start while busy=1 SHALL be ignored and not queued.
REQ-031 start asserted in the same cycle done pulses SHALL be ignored; it is accepted on the following IDLE cycle.
REQ-032 exponent=0 SHALL yield result=1 after E_WIDTH squarings.
REQ-033 The bit index SHALL be ceil(log2(E_WIDTH)) bits wide and SHALL never wrap below 0.

Reset
REQ-034 reset low SHALL immediately force:
- state to IDLE;
- busy, done, mm_enable and mm_reset to 0;
- result, mm_a, mm_b and acc to 0.
REQ-035 Reset asserted mid-operation SHALL abandon the transaction without emitting done; the first start after release begins a fresh computation.

Verification
(Bench uses a behavioural ModMul with p=251 and random latency of 1-6 cycles; P_WIDTH=8, E_WIDTH=4.)
REQ-036 base=3, exponent=4'b0101, start pulse -> 6 ModMul transactions (S,S,M,S,S,M), result=243, a single done pulse.
REQ-037 base=2, exponent=4'b1111 -> 8 transactions, result=138.
REQ-038 base=7, exponent=0 -> 4 squarings with mm_a=mm_b=1, result=1.
REQ-039 start re-pulsed with base=5 while busy -> ignored; the original job completes with the original result; the count of done pulses is 1.
REQ-040 reset driven low during the 3rd MUL_WAIT -> same cycle: mm_enable=0, busy=0, result=0, no done; after release, base=3, exponent=5 -> 243.
REQ-041 mm_done held high continuously by the stub between transactions -> each WAIT still lasts ≥2 cycles and the result is still correct.
